// File: rtl/result_drain_if.sv
// Bundle between the matmul controller/PE array, the C result BRAM write port and the drain block.
// Optional RESULT_DRAIN_OVERFLOW_EN adds the sticky overflow_out flag.
interface result_drain_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned M          = 3,
   parameter int unsigned N          = 3
);
   localparam int unsigned AW = (M * N > 1) ? $clog2(M * N) : 1;

   logic                        pe_output_capture_en;
   logic [M*N*DATA_WIDTH-1:0]   pe_results_in;
   logic                        wr_stall;
   logic                        en_c_bram_out;
   logic                        we_c_bram_out;
   logic [AW-1:0]               addr_c_bram_out;
   logic [DATA_WIDTH-1:0]       data_c_bram_out;
   logic                        busy_out;
   logic                        done_out;
`ifdef RESULT_DRAIN_OVERFLOW_EN
   logic                        overflow_out;

   modport master (
      output pe_output_capture_en, pe_results_in, wr_stall,
      input  en_c_bram_out, we_c_bram_out, addr_c_bram_out, data_c_bram_out,
      input  busy_out, done_out, overflow_out
   );
   modport slave (
      input  pe_output_capture_en, pe_results_in, wr_stall,
      output en_c_bram_out, we_c_bram_out, addr_c_bram_out, data_c_bram_out,
      output busy_out, done_out, overflow_out
   );
`else
   modport master (
      output pe_output_capture_en, pe_results_in, wr_stall,
      input  en_c_bram_out, we_c_bram_out, addr_c_bram_out, data_c_bram_out,
      input  busy_out, done_out
   );
   modport slave (
      input  pe_output_capture_en, pe_results_in, wr_stall,
      output en_c_bram_out, we_c_bram_out, addr_c_bram_out, data_c_bram_out,
      output busy_out, done_out
   );
`endif
endinterface

// File: rtl/result_drain.sv
// Snapshots the PE array results on a capture pulse and writes them one word per cycle into the
// C BRAM, honouring wr_stall. RESULT_DRAIN_OVERFLOW_EN enables the sticky overflow_out flag.
module result_drain #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned M          = 3,
   parameter int unsigned N          = 3
) (
   input logic           clk,
   input logic           rst,
   result_drain_if.slave bus
);
   localparam int unsigned NumElem = M * N;
   localparam int unsigned AW      = (NumElem > 1) ? $clog2(NumElem) : 1;
   localparam logic [AW-1:0] LastIdx = AW'(NumElem - 1);

   typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shadow_q [NumElem];
   logic                  capture;

   // Only an IDLE capture is accepted; pulses in DRAIN or DONE are dropped.
   assign capture = bus.pe_output_capture_en && (state_q == StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Shadow is the sole copy of the results; it needs no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int unsigned i = 0; i < NumElem; i++) begin
            shadow_q[i] <= bus.pe_results_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef RESULT_DRAIN_OVERFLOW_EN
   logic overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (bus.pe_output_capture_en && (state_q != StIdle)) begin
         overflow_q <= 1'b1;
      end
   end

   assign bus.overflow_out = overflow_q;
`endif

   always_comb begin
      state_d             = state_q;
      idx_d               = idx_q;
      bus.en_c_bram_out   = 1'b0;
      bus.we_c_bram_out   = 1'b0;
      bus.addr_c_bram_out = '0;
      bus.data_c_bram_out = '0;
      bus.busy_out        = 1'b0;
      bus.done_out        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               state_d = StDrain;
               idx_d   = '0;
            end
         end
         StDrain: begin
            bus.busy_out        = 1'b1;
            bus.en_c_bram_out   = !bus.wr_stall;
            bus.we_c_bram_out   = !bus.wr_stall;
            bus.addr_c_bram_out = idx_q;
            bus.data_c_bram_out = shadow_q[idx_q];
            if (!bus.wr_stall) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         StDone: begin
            bus.done_out = 1'b1;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end
endmodule
